// File: rtl/score_display_mux.sv
// Three-digit multiplexed seven-segment driver for the score tracker.
// Frame-aligned BCD capture, leading-zero blanking and a game-over blink sequence.

module seg_decode (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h40;
        case (bcd)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h40;
        endcase
    end
endmodule

module score_display_mux #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_ones,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_hundreds,
    input  logic       isGameComplete,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       game_over
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [RW-1:0] R_TC = RW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] F_TC = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {SHOW, BLINK_OFF, BLINK_ON} state_t;

    logic [RW-1:0]     rcnt;
    logic [1:0]        idx;
    logic [2:0][3:0]   sh;        // [0]=ones, [1]=tens, [2]=hundreds
    logic [2:0][6:0]   dig_seg;
    logic [2:0]        blank;
    state_t            state, state_n;
    logic [FW-1:0]     fcnt, fcnt_n;
    logic [1:0]        bcnt, bcnt_n;
    logic              rcnt_tc, fb;

    assign rcnt_tc = (rcnt == R_TC);
    assign fb      = rcnt_tc && (idx == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= 2'd0;
        end else if (rcnt_tc) begin
            rcnt <= '0;
            idx  <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    // Shadows only move at frame boundaries so a frame never mixes two scores.
    always_ff @(posedge clk) begin
        if (rst)
            sh <= '0;
        else if (fb)
            sh <= {bcd_hundreds, bcd_tens, bcd_ones};
    end

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dec
        seg_decode u_dec (
            .bcd (sh[g]),
            .seg (dig_seg[g])
        );
    end

    assign blank[0] = 1'b0;
    assign blank[1] = (sh[2] == 4'd0) && (sh[1] == 4'd0);
    assign blank[2] = (sh[2] == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHOW;
            fcnt  <= '0;
            bcnt  <= 2'd0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
            bcnt  <= bcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        bcnt_n  = bcnt;
        // A trigger in any state (re)starts the sequence and beats the frame step.
        if (isGameComplete) begin
            state_n = BLINK_OFF;
            fcnt_n  = '0;
            bcnt_n  = 2'd0;
        end else if (fb) begin
            case (state)
                BLINK_OFF: begin
                    if (fcnt == F_TC) begin
                        state_n = BLINK_ON;
                        fcnt_n  = '0;
                    end else begin
                        fcnt_n = fcnt + 1'b1;
                    end
                end
                BLINK_ON: begin
                    if (fcnt == F_TC) begin
                        fcnt_n = '0;
                        if (bcnt == 2'd2) begin
                            state_n = SHOW;
                        end else begin
                            state_n = BLINK_OFF;
                            bcnt_n  = bcnt + 2'd1;
                        end
                    end else begin
                        fcnt_n = fcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        an  = 3'b000;
        seg = 7'h00;
        if (state != BLINK_OFF) begin
            case (idx)
                2'd0: begin
                    an  = 3'b001;
                    seg = dig_seg[0];
                end
                2'd1: if (!blank[1]) begin
                    an  = 3'b010;
                    seg = dig_seg[1];
                end
                2'd2: if (!blank[2]) begin
                    an  = 3'b100;
                    seg = dig_seg[2];
                end
                default: ;
            endcase
        end
    end

    assign game_over = (state != SHOW);

endmodule

// File: doc/score_display_mux.md
# score_display_mux

Drives the multiplexed 3-digit seven-segment score display from the score tracker's BCD outputs, and flashes the display when a game ends. The block sits directly downstream of the score tracker, consuming `bcd_ones`, `bcd_tens`, `bcd_hundreds` and `isGameComplete`. It scans one digit at a time, blanks leading zeros, and latches new BCD values only at frame boundaries so the display never tears. On game completion it runs a fixed blink sequence.

## Interface
- REFRESH_DIV, 1000: clk cycles each digit stays selected (≥2).
- BLINK_FRAMES, 64: scan frames per blink half-period (≥1).
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- bcd_ones  in  4  ones digit from the score tracker.
- bcd_tens  in  4  tens digit.
- bcd_hundreds  in  4  hundreds digit.
- isGameComplete  in  1  game-over indication from the tracker; may be a 1-cycle pulse or held for several cycles.
- seg  out  7  segment drive, active-high; seg[0]=a … seg[6]=g.
- an  out  3  one-hot digit enable, active-high; an[0]=ones, an[1]=tens, an[2]=hundreds.
- game_over  out  1  high while a blink sequence runs.

## Operation
- **Refresh counter** `rcnt` counts 0..REFRESH_DIV-1 and wraps.
- **Digit index** `idx` advances 0→1→2→0 on the cycle where `rcnt` is at terminal count.
- **Frame boundary (FB):** `rcnt` is at terminal count and `idx==2`.
- **Shadow capture:** at each FB, the shadow registers `sh_o/sh_t/sh_h` load the three BCD inputs. Input changes between FBs have no visible effect. Capture also happens during blink.
- **Decode:** 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F. Codes 10–15 decode to 40 (dash).
- **Leading-zero blank:**
  - hundreds is blank if `sh_h==0`.
  - tens is blank if `sh_h==0` and `sh_t==0`.
  - ones is never blank.
  - A blank digit drives an=000, seg=00, but `idx` still advances.
- **Output rule:** seg and an are combinational from the registered `idx`, shadows and state.
  - Normal: an=one-hot(idx), seg=decode(selected shadow).
  - BLINK_OFF: an=000, seg=00.
- **FSM** (states SHOW, BLINK_OFF, BLINK_ON; counters `fcnt` 0..BLINK_FRAMES-1 and `bcnt` 0..2):
  - SHOW: `isGameComplete`=1 → BLINK_OFF, with `fcnt`=0 and `bcnt`=0.
  - BLINK_OFF: at each FB, `fcnt++`. At the FB with `fcnt==BLINK_FRAMES-1`, go to BLINK_ON and set `fcnt`=0.
  - BLINK_ON: at each FB, `fcnt++`. At the FB with `fcnt==BLINK_FRAMES-1`:
    - if `bcnt==2`, go to SHOW;
    - otherwise `bcnt++`, go to BLINK_OFF, set `fcnt`=0.
  - Retrigger: `isGameComplete`=1 in either blink state → BLINK_OFF with `fcnt`=`bcnt`=0. Retrigger has priority over the FB transition in the same cycle.
  - The first OFF phase may be partial because entry is not frame-aligned.
  - Total sequence is 3 OFF + 3 ON phases.
  - game_over = (state != SHOW).
- **Reset:** `rcnt`=0, `idx`=0, shadows=0, state=SHOW, `fcnt`=`bcnt`=0. Reset overrides everything, including mid-blink and mid-frame.

## Timing
- Reset values of the outputs (held throughout rst and on the first cycle after it): an=001, seg=3F, game_over=0.
- Digit dwell is exactly REFRESH_DIV cycles; a frame is 3×REFRESH_DIV cycles.
- Input-to-display latency:
  - BCD inputs sampled at an FB edge appear on the ones digit the cycle after that edge.
  - Worst case from an input change is 3×REFRESH_DIV cycles.
- `isGameComplete` sampled high at edge N gives an=000 and game_over=1 from cycle N+1.
- With a single trigger, game_over stays high until the FB ending the third ON phase, and drops the following cycle.
- A held `isGameComplete` keeps restarting the sequence, so the display stays OFF until it deasserts.

## Test plan
Bench parameters: REFRESH_DIV=4, BLINK_FRAMES=2.
1. **Reset and scan:** rst=1 for 3 cycles, BCD=0/0/0 → an=001, seg=3F during rst. After release: 4 cycles at an=001/3F, then 8 cycles at an=000/00 (tens and hundreds blanked), then ones again.
2. **Full value:** inputs 1/4/0 (score 140), wait one FB → frame shows 3F@001, 66@010, 06@100. Inputs 0/0/7 → only ones shown (07); tens and hundreds blank.
3. **No tearing:** change inputs 5→9 at `idx==1`, mid-frame → ones keeps showing 6D until the next FB, then shows 6F on the following cycle.
4. **Invalid code:** `bcd_tens`=12, `bcd_hundreds`=1 → tens digit seg=40.
5. **Blink sequence:** 1-cycle `isGameComplete` pulse → next cycle an=000 and game_over=1. Then ON/OFF alternates every 2 frames (24 cycles), with 3 ON phases. game_over falls after the third ON phase ends.
6. **Retrigger and reset:**
   - A second pulse during BLINK_ON → immediately OFF, sequence restarts.
   - rst=1 mid-blink → next cycle state=SHOW, an=001, seg=3F, game_over=0, shadows cleared.
